// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow async input in clk_in cycles.
// Optional 4-sample averaging of reported values: define PERIOD_AVG_EN.
module clock_period_meter #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic             i_clk_in,
   input  logic             i_rst_n,
   input  logic             i_sig_in,
   input  logic             i_enable,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high_time,
   output logic             o_meas_valid,
   output logic             o_timeout
);

   localparam logic [CNT_W-1:0] LP_TO   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LP_ZERO = '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_MEAS
   } state_t;

   state_t           r_state;
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [CNT_W-1:0] r_per_cnt;
   logic [CNT_W-1:0] r_hi_cnt;
   logic [CNT_W-1:0] r_hi_lat;
   logic [CNT_W-1:0] r_wait_cnt;

   logic             w_rise;
   logic             w_fall;
   logic             w_per_to;
   logic             w_wait_to;

   assign w_rise    = r_s2 & ~r_s3;
   assign w_fall    = ~r_s2 & r_s3;
   assign w_per_to  = (r_per_cnt == LP_TO);
   assign w_wait_to = (r_wait_cnt == LP_TO);

`ifdef PERIOD_AVG_EN
   logic [CNT_W+1:0] r_sum_p;
   logic [CNT_W+1:0] r_sum_h;
   logic [1:0]       r_avg_cnt;
   logic [CNT_W+1:0] w_sum_p_nxt;
   logic [CNT_W+1:0] w_sum_h_nxt;
   logic [CNT_W-1:0] w_avg_p;
   logic [CNT_W-1:0] w_avg_h;

   assign w_sum_p_nxt = r_sum_p + {2'b00, r_per_cnt};
   assign w_sum_h_nxt = r_sum_h + {2'b00, r_hi_lat};
   assign w_avg_p     = CNT_W'(w_sum_p_nxt >> 2);
   assign w_avg_h     = CNT_W'(w_sum_h_nxt >> 2);
`endif

   always_ff @(posedge i_clk_in) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_s3         <= 1'b0;
         r_per_cnt    <= LP_ZERO;
         r_hi_cnt     <= LP_ZERO;
         r_hi_lat     <= LP_ZERO;
         r_wait_cnt   <= LP_ZERO;
         o_period     <= LP_ZERO;
         o_high_time  <= LP_ZERO;
         o_meas_valid <= 1'b0;
         o_timeout    <= 1'b0;
`ifdef PERIOD_AVG_EN
         r_sum_p      <= '0;
         r_sum_h      <= '0;
         r_avg_cnt    <= 2'd0;
`endif
      end else begin
         r_s1         <= i_sig_in;
         r_s2         <= r_s1;
         r_s3         <= r_s2;
         o_meas_valid <= 1'b0;
         if (!i_enable) begin
            r_state    <= ST_IDLE;
            r_per_cnt  <= LP_ZERO;
            r_hi_cnt   <= LP_ZERO;
            r_hi_lat   <= LP_ZERO;
            r_wait_cnt <= LP_ZERO;
            o_timeout  <= 1'b0;
`ifdef PERIOD_AVG_EN
            r_sum_p    <= '0;
            r_sum_h    <= '0;
            r_avg_cnt  <= 2'd0;
`endif
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  r_state    <= ST_ARM;
                  r_wait_cnt <= LP_ONE;
               end
               ST_ARM: begin
                  if (w_rise) begin
                     r_state    <= ST_MEAS;
                     r_per_cnt  <= LP_ONE;
                     r_hi_cnt   <= LP_ONE;
                     r_wait_cnt <= LP_ZERO;
                  end else if (w_wait_to) begin
                     o_timeout   <= 1'b1;
                     o_period    <= LP_ZERO;
                     o_high_time <= LP_ZERO;
                     r_wait_cnt  <= LP_ONE;
`ifdef PERIOD_AVG_EN
                     r_sum_p     <= '0;
                     r_sum_h     <= '0;
                     r_avg_cnt   <= 2'd0;
`endif
                  end else begin
                     r_wait_cnt <= r_wait_cnt + LP_ONE;
                  end
               end
               ST_MEAS: begin
                  if (w_fall) begin
                     r_hi_lat <= r_hi_cnt;
                  end
                  // A rise on the threshold cycle still counts as valid
                  if (w_rise) begin
                     r_per_cnt <= LP_ONE;
                     r_hi_cnt  <= LP_ONE;
`ifdef PERIOD_AVG_EN
                     r_avg_cnt <= r_avg_cnt + 2'd1;
                     if (r_avg_cnt == 2'd3) begin
                        o_period     <= w_avg_p;
                        o_high_time  <= w_avg_h;
                        o_meas_valid <= 1'b1;
                        o_timeout    <= 1'b0;
                        r_sum_p      <= '0;
                        r_sum_h      <= '0;
                     end else begin
                        r_sum_p <= w_sum_p_nxt;
                        r_sum_h <= w_sum_h_nxt;
                     end
`else
                     o_period     <= r_per_cnt;
                     o_high_time  <= r_hi_lat;
                     o_meas_valid <= 1'b1;
                     o_timeout    <= 1'b0;
`endif
                  end else if (w_per_to) begin
                     r_state     <= ST_ARM;
                     o_timeout   <= 1'b1;
                     o_period    <= LP_ZERO;
                     o_high_time <= LP_ZERO;
                     r_per_cnt   <= LP_ZERO;
                     r_hi_cnt    <= LP_ZERO;
                     r_wait_cnt  <= LP_ONE;
`ifdef PERIOD_AVG_EN
                     r_sum_p     <= '0;
                     r_sum_h     <= '0;
                     r_avg_cnt   <= 2'd0;
`endif
                  end else begin
                     r_per_cnt <= r_per_cnt + LP_ONE;
                     if (r_s2) begin
                        r_hi_cnt <= r_hi_cnt + LP_ONE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised bench for clock_period_meter against a timestamp-based model.
// Default build only (PERIOD_AVG_EN undefined).
module tb_clock_period_meter;

   localparam int unsigned CNT_W = 32;
   localparam int unsigned TO    = 500;

   logic             clk;
   logic             rst_n;
   logic             sig;
   logic             en;
   logic [CNT_W-1:0] o_period;
   logic [CNT_W-1:0] o_high_time;
   logic             o_meas_valid;
   logic             o_timeout;

   int checks = 0;
   int errors = 0;

   clock_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TO)
   ) dut (
      .i_clk_in     (clk),
      .i_rst_n      (rst_n),
      .i_sig_in     (sig),
      .i_enable     (en),
      .o_period     (o_period),
      .o_high_time  (o_high_time),
      .o_meas_valid (o_meas_valid),
      .o_timeout    (o_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: rises/falls as edge timestamps; period and high time are
   // differences between them, timeouts measured from the last restart.
   longint    n = 0;
   bit        q0, q1, q2;
   int        mode = 0;
   longint    ref_t, rise_t, fall_t;
   bit        rise, fall;
   logic [31:0] m_per = '0;
   logic [31:0] m_hi  = '0;
   bit        m_val = 1'b0;
   bit        m_to  = 1'b0;

   always @(posedge clk) begin
      n++;
      if (!rst_n) begin
         mode = 0;
         q0 = 0; q1 = 0; q2 = 0;
         m_per = '0; m_hi = '0; m_val = 0; m_to = 0;
      end else begin
         rise  = q1 && !q2;
         fall  = !q1 && q2;
         m_val = 0;
         if (!en) begin
            mode = 0;
            m_to = 0;
         end else if (mode == 0) begin
            mode  = 1;
            ref_t = n;
         end else if (mode == 1) begin
            if (rise) begin
               mode = 2; rise_t = n; fall_t = n; ref_t = n;
            end else if (n - ref_t == TO) begin
               m_to = 1; m_per = '0; m_hi = '0; ref_t = n;
            end
         end else begin
            if (fall) fall_t = n;
            if (rise) begin
               m_per  = 32'(n - rise_t);
               m_hi   = 32'(fall_t - rise_t);
               m_val  = 1; m_to = 0;
               rise_t = n; ref_t = n;
            end else if (n - ref_t == TO) begin
               m_to = 1; m_per = '0; m_hi = '0;
               mode = 1; ref_t = n;
            end
         end
         q2 = q1; q1 = q0; q0 = sig;
      end
      #1;
      check("m_period", 64'(o_period), 64'(m_per));
      check("m_high",   64'(o_high_time), 64'(m_hi));
      check("m_valid",  64'(o_meas_valid), 64'(m_val));
      check("m_timeout", 64'(o_timeout), 64'(m_to));
   end

   task automatic wave(input int hi, input int lo, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         sig = 1'b1;
         repeat (hi) @(negedge clk);
         sig = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   initial begin
      int k;
      int hi, lo, cnt;
      rst_n = 1'b0;
      en    = 1'b0;
      sig   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_period", 64'(o_period), 64'd0);
      check("rst_high", 64'(o_high_time), 64'd0);
      check("rst_valid", 64'(o_meas_valid), 64'd0);
      check("rst_timeout", 64'(o_timeout), 64'd0);

      rst_n = 1'b1;
      en    = 1'b1;
      repeat (5) @(negedge clk);
      wave(50, 50, 4);
      check("lock_period", 64'(o_period), 64'd100);
      check("lock_high", 64'(o_high_time), 64'd50);

      wave(30, 70, 3);
      check("duty_period", 64'(o_period), 64'd100);
      check("duty_high", 64'(o_high_time), 64'd30);

      k = 0;
      while (!o_timeout && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("loss_timeout", 64'(o_timeout), 64'd1);
      check("loss_period", 64'(o_period), 64'd0);
      check("loss_high", 64'(o_high_time), 64'd0);

      wave(50, 50, 1);
      check("rearm_timeout", 64'(o_timeout), 64'd1);
      wave(50, 50, 1);
      check("relock_timeout", 64'(o_timeout), 64'd0);
      check("relock_period", 64'(o_period), 64'd100);

      sig = 1'b1;
      repeat (20) @(negedge clk);
      en = 1'b0;
      repeat (30) @(negedge clk);
      wave(50, 50, 2);
      check("dis_period", 64'(o_period), 64'd100);
      check("dis_timeout", 64'(o_timeout), 64'd0);
      en = 1'b1;
      wave(40, 60, 3);
      check("reen_period", 64'(o_period), 64'd100);
      check("reen_high", 64'(o_high_time), 64'd40);

      sig = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_period", 64'(o_period), 64'd0);
      check("mid_rst_timeout", 64'(o_timeout), 64'd0);
      wave(50, 50, 3);
      check("post_rst_period", 64'(o_period), 64'd100);

      // Period equal to the timeout threshold: rise must win.
      wave(250, 250, 3);
      check("tie_period", 64'(o_period), 64'(TO));
      check("tie_timeout", 64'(o_timeout), 64'd0);

      for (int b = 0; b < 60; b++) begin
         hi  = int'($urandom_range(1, 60));
         lo  = int'($urandom_range(1, 60));
         cnt = int'($urandom_range(1, 4));
         wave(hi, lo, cnt);
         if ($urandom_range(0, 7) == 0) begin
            sig = $urandom_range(0, 1) == 1;
            repeat ($urandom_range(400, 700)) @(negedge clk);
         end
         if ($urandom_range(0, 9) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            en = 1'b1;
         end
         if ($urandom_range(0, 14) == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Measures an asynchronous, slow square-wave input, such as a divided clock or PWM output looped back, in units of the system clock.
- Reports the period (rising edge to rising edge) and high time on every completed cycle, with a one-cycle valid strobe.
- Flags loss of the input signal with a timeout.
- Sits opposite the clock divider: the divider generates a slow clock, and this block verifies or characterises it. The SPI register file reads the results.

Parameters:
- CNT_W, 32: width of the period and high-time counters and outputs.
- TIMEOUT, 1000000: clk_in cycles without a rising edge before the timeout flag sets. Must satisfy 2 <= TIMEOUT < 2^CNT_W.

Ports:
- clk_in, input, 1: system clock (100 MHz).
- rst_n, input, 1: synchronous active-low reset, sampled on the clk_in rising edge.
- sig_in, input, 1: asynchronous signal being measured.
- enable, input, 1: measurement enable; low forces IDLE.
- period, output, CNT_W: last measured period, in clk_in cycles.
- high_time, output, CNT_W: last measured high time, in clk_in cycles.
- meas_valid, output, 1: one-cycle pulse when period and high_time update.
- timeout, output, 1: level; set on signal loss.

Behaviour:
- Reset (rst_n=0 at a clk_in edge):
  - period=0, high_time=0, meas_valid=0, timeout=0.
  - Synchronizer flops=0; state=IDLE; all counters=0.
- Synchronizer and edge detection:
  - Two-flop synchronizer s1 -> s2, plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency: meas_valid rises on the 3rd clk_in edge after the sig_in rising edge that meets setup.
- States:
  - IDLE -> ARM when enable=1.
  - ARM: wait for rise. On rise: per_cnt<=1, hi_cnt<=1, go to MEAS. No output update.
  - MEAS, each cycle:
    - per_cnt increments.
    - hi_cnt increments while s2=1.
    - On fall: hi_lat<=hi_cnt.
    - On rise: period<=per_cnt, high_time<=hi_lat, meas_valid<=1, timeout<=0, per_cnt<=1, hi_cnt<=1.
  - Any state, enable=0: go to IDLE next cycle. Counters clear, period/high_time hold, timeout clears, meas_valid=0.
- Counting convention: a signal with N cycles between detected rises and H cycles of s2 high reports period=N, high_time=H.
- Timeout:
  - Triggers in MEAS when per_cnt reaches TIMEOUT without a rise.
  - Effects: timeout<=1, period<=0, high_time<=0, no meas_valid, go to ARM.
  - timeout stays high until the next valid measurement, enable=0, or reset.
  - In ARM, a separate wait counter applies the same TIMEOUT rule; timeout sets if no first rise arrives. The counter restarts after each expiry.
- Boundaries:
  - rise and the timeout threshold in the same cycle: rise wins, and the measurement is valid.
  - Constant-high or constant-low input: timeout.
  - A glitch shorter than one clk_in cycle may be missed. No filtering is done.
  - Counters never wrap, because TIMEOUT bounds them.
  - Reset mid-measurement: immediate return to the reset values above.

Optional Feature:
- Macro: PERIOD_AVG_EN.
- Defined:
  - Each MEAS rise accumulates per_cnt and hi_lat into (CNT_W+2)-bit sums.
  - On every 4th rise, period=sum_p>>2, high_time=sum_h>>2 (truncated), meas_valid pulses, and the sums clear.
  - Timeout, enable=0, or reset also clear the sums and the 2-bit rise count.
- Not defined: per-cycle update as described under Behaviour. No accumulator logic is present.

Test Plan:
- sig_in from a divider of 100 MHz by 100 (50 high / 50 low), enable=1 -> first meas_valid after the 2nd rise; period=100, high_time=50; then a pulse every 100 cycles.
- Duty change to 30 high / 70 low -> period=100, high_time=30 from the first full cycle after the change.
- TIMEOUT=500; stop sig_in low after lock -> timeout=1 exactly 500 cycles after the last per_cnt reset; period=0, high_time=0. Restart the input -> timeout clears with the 2nd new rise's meas_valid.
- enable=0 mid-measurement -> no meas_valid, outputs hold, timeout=0. Re-enable -> ARM; first valid after 2 rises.
- rst_n=0 for 1 cycle mid-MEAS -> all outputs 0 next cycle; measurement restarts from ARM.
- PERIOD_AVG_EN, with periods 100, 102, 98, 104 -> a single meas_valid with period=101.
